fsm_datapath: RTL

//   Datapath consumed by the 4-bit JK controller FSM: three WIDTH-bit registers (X, S, H), operand muxes
//   and a small ALU driven directly by the controller's m0/m1/m2/lx/ls/lh/h/done outputs.
//   On done it captures S into an output register and offers it downstream with valid/ready.

---
 rtl/fsm_datapath.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fsm_datapath.sv
// fsm_datapath
//   Datapath driven by a JK-style controller FSM. Holds three WIDTH-bit working
//   registers (X, S, H), two operand muxes and a small ALU. The controller picks
//   operands (m0/m1), the ALU op (m2), optional arithmetic halving (h) and which
//   registers load the writeback value (lx/ls/lh). On done, S is captured into an
//   output register and offered downstream with a valid/ready handshake.
//   Status flags zero/neg feed back to the controller; ovf/overrun are sticky.
// Ports
//   clk, rst            clock (posedge) and asynchronous active-high reset
//   din                 external operand, operand A when m0 = 2'b11
//   m0, m1, m2          operand A select, operand B select, ALU op
//   lx, ls, lh, h       register load enables and halve control
//   done                capture S into dout
//   dout, dout_valid,
//   dout_ready          output result handshake
//   zero, neg           flags of the last written writeback value
//   ovf, overrun        sticky signed-overflow and dropped-result flags
module fsm_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       m0,
  input  logic [1:0]       m1,
  input  logic [1:0]       m2,
  input  logic             lx,
  input  logic             ls,
  input  logic             lh,
  input  logic             h,
  input  logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             overrun
);

  logic [WIDTH-1:0] r_x, r_s, r_h;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_zero, r_neg, r_ovf, r_overrun;

  logic [WIDTH-1:0] w_a, w_b, w_r, w_wb;
  logic             w_load;
  logic             w_ovf;

  // Operand A select
  always_comb begin
    w_a = '0;
    case (m0)
      2'b00:   w_a = r_x;
      2'b01:   w_a = r_s;
      2'b10:   w_a = r_h;
      2'b11:   w_a = din;
      default: w_a = '0;
    endcase
  end

  // Operand B select
  always_comb begin
    w_b = '0;
    case (m1)
      2'b00:   w_b = r_x;
      2'b01:   w_b = r_s;
      2'b10:   w_b = r_h;
      2'b11:   w_b = {{(WIDTH-1){1'b0}}, 1'b1};
      default: w_b = '0;
    endcase
  end

  // ALU with signed-overflow detection for add/sub (before halving)
  always_comb begin
    w_r   = '0;
    w_ovf = 1'b0;
    case (m2)
      2'b00: begin
        w_r   = w_a + w_b;
        w_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_r[WIDTH-1] != w_a[WIDTH-1]);
      end
      2'b01: begin
        w_r   = w_a - w_b;
        w_ovf = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_r[WIDTH-1] != w_a[WIDTH-1]);
      end
      2'b10:   w_r = {w_a[WIDTH-2:0], 1'b0};
      2'b11:   w_r = w_a;
      default: w_r = '0;
    endcase
  end

  // Writeback value: optional arithmetic shift right by one
  always_comb begin
    if (h) begin
      w_wb = {w_r[WIDTH-1], w_r[WIDTH-1:1]};
    end else begin
      w_wb = w_r;
    end
  end

  assign w_load = lx | ls | lh;

  // Working registers and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x    <= '0;
      r_s    <= '0;
      r_h    <= '0;
      r_zero <= 1'b1;
      r_neg  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (lx) r_x <= w_wb;
      if (ls) r_s <= w_wb;
      if (lh) r_h <= w_wb;
      if (w_load) begin
        r_zero <= (w_wb == '0);
        r_neg  <= w_wb[WIDTH-1];
        if (w_ovf) r_ovf <= 1'b1;
      end
    end
  end

  // Output capture and valid/ready handshake; done always wins and reloads dout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (done) begin
        r_dout       <= r_s;
        r_dout_valid <= 1'b1;
        // Replacing a result nobody took this cycle loses it
        if (r_dout_valid && !dout_ready) r_overrun <= 1'b1;
      end else if (r_dout_valid && dout_ready) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign zero       = r_zero;
  assign neg        = r_neg;
  assign ovf        = r_ovf;
  assign overrun    = r_overrun;

endmodule
